mdr_unit: RTL and testbench

Parametrised memory data register with a memory-side request/ready handshake, replacing the single-cycle MDR in the datapath. Holds a DATA_W-bit value loadable from the datapath bus or from memory. Memory reads extract byte/halfword/word lanes with sign or zero extension. Memory writes drive lane-replicated data with byte enables. Sits between the datapath bus and the memory interface.

---
 rtl/mdr_unit.sv | 163 ++++++++++++++++
 tb/tb_mdr_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdr_unit.sv
// mdr_unit: memory data register with a request/ready memory handshake.
// Loads from the datapath bus or from memory (byte/halfword/word lanes with
// sign or zero extension) and drives lane-replicated write data with byte
// enables. Optional macro MDR_TIMEOUT_EN adds a per-transaction wait limit
// of TIMEOUT edges; without it the wait states hold until mem_ready.
module mdr_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    localparam int OFF_W  = $clog2(DATA_W/8),
    localparam int NB     = DATA_W/8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              MDR_enable,
    input  logic              Read,
    input  logic              Write,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [OFF_W-1:0]  byte_off,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [NB-1:0]     mem_be,
    output logic [DATA_W-1:0] MDR_data_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_mdr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [OFF_W-1:0]  r_off;
    logic              r_done;
    logic              r_err;
    logic              w_misaligned;
    logic [DATA_W-1:0] w_wdata;
    logic [NB-1:0]     w_be;

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  r_cnt;
`else
    // The limit only matters when the timeout counter is built in.
    logic              w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // Pull the addressed lane out of a read word and widen it to DATA_W.
    function automatic logic [DATA_W-1:0] f_extract(
        input logic [DATA_W-1:0] rd,
        input logic [1:0]        sz,
        input logic              uns,
        input logic [OFF_W-1:0]  off
    );
        logic [DATA_W-1:0] sh;
        sh = rd >> (8 * off);
        case (sz)
            2'b00:   f_extract = uns ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                                     : {{(DATA_W-8){sh[7]}}, sh[7:0]};
            2'b01:   f_extract = uns ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                                     : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: f_extract = rd;
        endcase
    endfunction

    // Halfword needs an even offset; word needs offset zero.
    assign w_misaligned = ((size == 2'b01) && byte_off[0]) ||
                          (size[1] && (byte_off != '0));

    // Write data and byte enables decode from registered state only.
    always_comb begin
        w_wdata = '0;
        w_be    = '0;
        if (r_state == S_WR_WAIT) begin
            for (int i = 0; i < NB; i++) begin
                case (r_size)
                    2'b00:   w_wdata[8*i +: 8] = r_mdr[7:0];
                    2'b01:   w_wdata[8*i +: 8] = r_mdr[8*(i%2) +: 8];
                    default: w_wdata[8*i +: 8] = r_mdr[8*i +: 8];
                endcase
            end
            case (r_size)
                2'b00:   w_be = NB'(1) << r_off;
                2'b01:   w_be = NB'(3) << r_off;
                default: w_be = '1;
            endcase
        end
    end

    // Handshake FSM, MDR loads, and one-cycle done/err pulses.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_mdr   <= '0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_off   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Read || Write) begin
                        if (w_misaligned) begin
                            r_err <= 1'b1;
                        end else begin
                            r_size  <= size;
                            r_uns   <= unsigned_ld;
                            r_off   <= byte_off;
                            r_state <= Read ? S_RD_WAIT : S_WR_WAIT;
`ifdef MDR_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end else if (MDR_enable) begin
                        r_mdr <= bus_data;
                    end
                end
                S_RD_WAIT, S_WR_WAIT: begin
                    if (mem_ready) begin
                        if (r_state == S_RD_WAIT)
                            r_mdr <= f_extract(mem_rdata, r_size, r_uns, r_off);
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
`ifdef MDR_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req      = (r_state != S_IDLE);
    assign mem_we       = (r_state == S_WR_WAIT);
    assign mem_wdata    = w_wdata;
    assign mem_be       = w_be;
    assign MDR_data_out = r_mdr;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_mdr_unit.sv
// Directed self-checking bench for mdr_unit (DATA_W=32, TIMEOUT=4).
module tb_mdr_unit;
    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] bus_data;
    logic        MDR_enable, Read, Write;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [1:0]  byte_off;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] MDR_data_out;
    logic        busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    mdr_unit #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clock(clock), .clear(clear), .bus_data(bus_data), .MDR_enable(MDR_enable),
        .Read(Read), .Write(Write), .size(size), .unsigned_ld(unsigned_ld),
        .byte_off(byte_off), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .MDR_data_out(MDR_data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle past it before looking at outputs.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        MDR_enable = 1'b1; bus_data = v;
        tick();
        MDR_enable = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        tick(); tick();
        n_tests++; if (MDR_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_mdr got %h want %h", MDR_data_out, 32'h0); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if ({done, err, mem_we, mem_be} !== 7'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0", {done, err, mem_we, mem_be}); end
        clear = 1'b1;
        load_mdr(32'h11111111);
        n_tests++; if (MDR_data_out !== 32'h11111111) begin n_fail++; $display("FAIL bus_load got %h want 11111111", MDR_data_out); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL bus_load_done got %b want 0", done); end
    endtask

    task automatic test_word_read();
        int done_cnt;
        Read = 1'b1; size = 2'b10; byte_off = 2'd0; unsigned_ld = 1'b0;
        tick();
        Read = 1'b0;
        n_tests++; if ({mem_req, mem_we, busy} !== 3'b101) begin n_fail++; $display("FAIL wr_req_we_busy got %b want 101", {mem_req, mem_we, busy}); end
        tick(); tick();
        n_tests++; if ({mem_req, done} !== 2'b10) begin n_fail++; $display("FAIL wread_wait got %b want 10", {mem_req, done}); end
        mem_rdata = 32'hDEADBEEF; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        done_cnt = int'(done);
        n_tests++; if (MDR_data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wread_mdr got %h want deadbeef", MDR_data_out); end
        n_tests++; if ({mem_req, busy} !== 2'b00) begin n_fail++; $display("FAIL wread_idle got %b want 00", {mem_req, busy}); end
        tick();
        done_cnt += int'(done);
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL wread_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic test_subword_reads();
        logic [1:0]  t_sz [5]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        t_un [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  t_off[5]  = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
        logic [31:0] t_exp[5]  = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'h00007F00, 32'h0000007F};
        for (int k = 0; k < 5; k++) begin
            Read = 1'b1; size = t_sz[k]; unsigned_ld = t_un[k]; byte_off = t_off[k];
            tick();
            Read = 1'b0; size = 2'b10; unsigned_ld = ~t_un[k]; byte_off = 2'd3;
            mem_rdata = 32'h80F17F00; mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            n_tests++; if (MDR_data_out !== t_exp[k]) begin n_fail++; $display("FAIL subread_%0d got %h want %h", k, MDR_data_out, t_exp[k]); end
        end
    endtask

    task automatic test_writes();
        load_mdr(32'h000000AB);
        Write = 1'b1; size = 2'b00; byte_off = 2'd3;
        tick();
        Write = 1'b0;
        n_tests++; if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL bwrite_req got %b want 11", {mem_req, mem_we}); end
        n_tests++; if (mem_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL bwrite_data got %h want abababab", mem_wdata); end
        n_tests++; if (mem_be !== 4'b1000) begin n_fail++; $display("FAIL bwrite_be got %b want 1000", mem_be); end
        tick();
        n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL bwrite_hold got %b want 1", mem_we); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_tests++; if ({mem_req, mem_we, done} !== 3'b001) begin n_fail++; $display("FAIL bwrite_end got %b want 001", {mem_req, mem_we, done}); end
        n_tests++; if ({mem_wdata, mem_be} !== 36'h0) begin n_fail++; $display("FAIL bwrite_idle_bus got %h want 0", {mem_wdata, mem_be}); end
        n_tests++; if (MDR_data_out !== 32'h000000AB) begin n_fail++; $display("FAIL bwrite_mdr got %h want 000000ab", MDR_data_out); end
        // Aligned halfword at lane 2.
        Write = 1'b1; size = 2'b01; byte_off = 2'd2;
        tick();
        Write = 1'b0;
        n_tests++; if ({mem_wdata, mem_be} !== {32'h00AB00AB, 4'b1100}) begin n_fail++; $display("FAIL hwrite got %h/%b want 00ab00ab/1100", mem_wdata, mem_be); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        // Misaligned halfword.
        Write = 1'b1; size = 2'b01; byte_off = 2'd1;
        tick();
        Write = 1'b0;
        n_tests++; if ({err, mem_req, busy, done} !== 4'b1000) begin n_fail++; $display("FAIL hwrite_mis got %b want 1000", {err, mem_req, busy, done}); end
        tick();
        n_tests++; if ({err, mem_req} !== 2'b00) begin n_fail++; $display("FAIL hwrite_mis_after got %b want 00", {err, mem_req}); end
        // Misaligned word read leaves the MDR alone.
        Read = 1'b1; size = 2'b11; byte_off = 2'd2; mem_rdata = 32'hFFFFFFFF;
        tick();
        Read = 1'b0;
        n_tests++; if ({err, mem_req, MDR_data_out} !== {2'b10, 32'h000000AB}) begin n_fail++; $display("FAIL wread_mis got %b/%h want 10/000000ab", {err, mem_req}, MDR_data_out); end
    endtask

    task automatic test_contention();
        // mem_ready while idle must be ignored.
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0;
        n_tests++; if ({MDR_data_out, done} !== {32'h000000AB, 1'b0}) begin n_fail++; $display("FAIL idle_ready got %h/%b want 000000ab/0", MDR_data_out, done); end
        Read = 1'b1; Write = 1'b1; size = 2'b10; byte_off = 2'd0;
        tick();
        Read = 1'b0; Write = 1'b0;
        n_tests++; if ({mem_req, mem_we} !== 2'b10) begin n_fail++; $display("FAIL rw_both got %b want 10", {mem_req, mem_we}); end
        MDR_enable = 1'b1; bus_data = 32'h55555555;
        tick();
        MDR_enable = 1'b0;
        n_tests++; if (MDR_data_out !== 32'h000000AB) begin n_fail++; $display("FAIL enable_in_wait got %h want 000000ab", MDR_data_out); end
        mem_rdata = 32'h12345678; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_tests++; if (MDR_data_out !== 32'h12345678) begin n_fail++; $display("FAIL rw_both_mdr got %h want 12345678", MDR_data_out); end
        // Reset during a read aborts it silently.
        Read = 1'b1; size = 2'b10; byte_off = 2'd0;
        tick();
        Read = 1'b0;
        clear = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hAAAAAAAA;
        tick();
        clear = 1'b1; mem_ready = 1'b0;
        n_tests++; if ({mem_req, busy, done} !== 3'b000) begin n_fail++; $display("FAIL abort got %b want 000", {mem_req, busy, done}); end
        n_tests++; if (MDR_data_out !== 32'h0) begin n_fail++; $display("FAIL abort_mdr got %h want 0", MDR_data_out); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
    endtask

    task automatic test_timeout();
        load_mdr(32'h0F0F0F0F);
        Read = 1'b1; size = 2'b10; byte_off = 2'd0;
        tick();
        Read = 1'b0;
`ifdef MDR_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if ({busy, err} !== 2'b10) begin n_fail++; $display("FAIL tmo_wait_%0d got %b want 10", k, {busy, err}); end
        end
        tick();
        n_tests++; if ({busy, mem_req, err, done} !== 4'b0010) begin n_fail++; $display("FAIL tmo_expire got %b want 0010", {busy, mem_req, err, done}); end
        n_tests++; if (MDR_data_out !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL tmo_mdr got %h want 0f0f0f0f", MDR_data_out); end
        tick();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_pulse got %b want 0", err); end
`else
        repeat (100) tick();
        n_tests++; if ({busy, mem_req, err} !== 3'b110) begin n_fail++; $display("FAIL no_tmo got %b want 110", {busy, mem_req, err}); end
        clear = 1'b0; tick(); clear = 1'b1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL no_tmo_reset got %b want 0", busy); end
`endif
    endtask

    initial begin
        clear = 1'b0; bus_data = '0; MDR_enable = 1'b0; Read = 1'b0; Write = 1'b0;
        size = 2'b00; unsigned_ld = 1'b0; byte_off = '0; mem_rdata = '0; mem_ready = 1'b0;
        test_reset();
        test_word_read();
        test_subword_reads();
        test_writes();
        test_contention();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
